// File: rtl/pic_isa_pkg.sv
// Shared PIC16F-class ISA definitions: 14-bit opcode match patterns, ALU op codes,
// instruction classes, the sequencer state enum and the opcode classifier.
package pic_isa_pkg;

  localparam int ISA_W = 14;

  localparam logic [3:0] ALU_NOP    = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_AND    = 4'd3;
  localparam logic [3:0] ALU_IOR    = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_CLR    = 4'd6;
  localparam logic [3:0] ALU_INC    = 4'd7;
  localparam logic [3:0] ALU_DEC    = 4'd8;
  localparam logic [3:0] ALU_COM    = 4'd9;
  localparam logic [3:0] ALU_PASS_F = 4'd10;
  localparam logic [3:0] ALU_PASS_W = 4'd11;
  localparam logic [3:0] ALU_PASS_L = 4'd12;
  localparam logic [3:0] ALU_BTST   = 4'd13;

  typedef enum logic [1:0] {EXEC, FLUSH, HALT} seq_state_e;

  typedef enum logic [2:0] {C_NOP, C_ALU, C_SKIP, C_GOTO, C_CALL, C_RET, C_RETLW} instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   op;
    logic         status_wr;
    logic         literal;
  } decode_t;

  localparam logic [ISA_W-1:0] OP_MOVWF  = 14'b00_0000_1???_????;
  localparam logic [ISA_W-1:0] OP_RETURN = 14'b00_0000_0000_1000;
  localparam logic [ISA_W-1:0] OP_CLRW   = 14'b00_0001_0???_????;
  localparam logic [ISA_W-1:0] OP_CLRF   = 14'b00_0001_1???_????;
  localparam logic [ISA_W-1:0] OP_SUBWF  = 14'b00_0010_????_????;
  localparam logic [ISA_W-1:0] OP_DECF   = 14'b00_0011_????_????;
  localparam logic [ISA_W-1:0] OP_IORWF  = 14'b00_0100_????_????;
  localparam logic [ISA_W-1:0] OP_ANDWF  = 14'b00_0101_????_????;
  localparam logic [ISA_W-1:0] OP_XORWF  = 14'b00_0110_????_????;
  localparam logic [ISA_W-1:0] OP_ADDWF  = 14'b00_0111_????_????;
  localparam logic [ISA_W-1:0] OP_MOVF   = 14'b00_1000_????_????;
  localparam logic [ISA_W-1:0] OP_COMF   = 14'b00_1001_????_????;
  localparam logic [ISA_W-1:0] OP_INCF   = 14'b00_1010_????_????;
  localparam logic [ISA_W-1:0] OP_DECFSZ = 14'b00_1011_????_????;
  localparam logic [ISA_W-1:0] OP_INCFSZ = 14'b00_1111_????_????;
  localparam logic [ISA_W-1:0] OP_BTFSC  = 14'b01_10??_????_????;
  localparam logic [ISA_W-1:0] OP_BTFSS  = 14'b01_11??_????_????;
  localparam logic [ISA_W-1:0] OP_CALL   = 14'b10_0???_????_????;
  localparam logic [ISA_W-1:0] OP_GOTO   = 14'b10_1???_????_????;
  localparam logic [ISA_W-1:0] OP_MOVLW  = 14'b11_00??_????_????;
  localparam logic [ISA_W-1:0] OP_RETLW  = 14'b11_01??_????_????;
  localparam logic [ISA_W-1:0] OP_ANDLW  = 14'b11_1001_????_????;
  localparam logic [ISA_W-1:0] OP_ADDLW  = 14'b11_111?_????_????;

  // Anything not listed falls through to C_NOP, so unknown opcodes execute as NOP.
  function automatic decode_t decode_instr(input logic [ISA_W-1:0] instr);
    decode_t d;
    d = '{C_NOP, ALU_NOP, 1'b0, 1'b0};
    casez (instr)
      OP_MOVWF:         d = '{C_ALU,  ALU_PASS_W, 1'b0, 1'b0};
      OP_RETURN:        d = '{C_RET,  ALU_NOP,    1'b0, 1'b0};
      OP_CLRW, OP_CLRF: d = '{C_ALU,  ALU_CLR,    1'b1, 1'b0};
      OP_SUBWF:         d = '{C_ALU,  ALU_SUB,    1'b1, 1'b0};
      OP_DECF:          d = '{C_ALU,  ALU_DEC,    1'b1, 1'b0};
      OP_IORWF:         d = '{C_ALU,  ALU_IOR,    1'b1, 1'b0};
      OP_ANDWF:         d = '{C_ALU,  ALU_AND,    1'b1, 1'b0};
      OP_XORWF:         d = '{C_ALU,  ALU_XOR,    1'b1, 1'b0};
      OP_ADDWF:         d = '{C_ALU,  ALU_ADD,    1'b1, 1'b0};
      OP_MOVF:          d = '{C_ALU,  ALU_PASS_F, 1'b1, 1'b0};
      OP_COMF:          d = '{C_ALU,  ALU_COM,    1'b1, 1'b0};
      OP_INCF:          d = '{C_ALU,  ALU_INC,    1'b1, 1'b0};
      OP_DECFSZ:        d = '{C_SKIP, ALU_DEC,    1'b1, 1'b0};
      OP_INCFSZ:        d = '{C_SKIP, ALU_INC,    1'b1, 1'b0};
      OP_BTFSC:         d = '{C_SKIP, ALU_BTST,   1'b1, 1'b0};
      OP_BTFSS:         d = '{C_SKIP, ALU_BTST,   1'b1, 1'b0};
      OP_CALL:          d = '{C_CALL, ALU_NOP,    1'b0, 1'b0};
      OP_GOTO:          d = '{C_GOTO, ALU_NOP,    1'b0, 1'b0};
      OP_MOVLW:         d = '{C_ALU,  ALU_PASS_L, 1'b0, 1'b1};
      OP_RETLW:         d = '{C_RETLW, ALU_PASS_L, 1'b0, 1'b1};
      OP_ANDLW:         d = '{C_ALU,  ALU_AND,    1'b1, 1'b1};
      OP_ADDLW:         d = '{C_ALU,  ALU_ADD,    1'b1, 1'b1};
      default:          d = '{C_NOP, ALU_NOP, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-register / ALU / PC / stack control bundle of the Q-cycle sequencer.
// The sequencer uses the slave modport; the core side (or a bench) uses master.
interface instr_sequencer_if #(
  parameter int INSTR_W  = 14,
  parameter int ALU_OP_W = 4,
  parameter int Q_W      = 2
);
  logic [INSTR_W-1:0]  instr_current;
  logic                skip_cond;
  logic                halt_req;
  logic                halted;
  logic [Q_W-1:0]      q_phase;
  logic                alu_status_wr_en;
  logic                alu_sel_l;
  logic                alu_d;
  logic                alu_d_wr_en;
  logic [ALU_OP_W-1:0] alu_op;
  logic                instr_rd_en;
  logic                instr_flush;
  logic                pc_incr_en;
  logic                pc_j_en;
  logic                stack_push;
  logic                stack_pop;
  logic                pc_ret_en;

  modport master (
    output instr_current, skip_cond, halt_req,
    input  halted, q_phase, alu_status_wr_en, alu_sel_l, alu_d, alu_d_wr_en, alu_op,
           instr_rd_en, instr_flush, pc_incr_en, pc_j_en, stack_push, stack_pop, pc_ret_en
  );

  modport slave (
    input  instr_current, skip_cond, halt_req,
    output halted, q_phase, alu_status_wr_en, alu_sel_l, alu_d, alu_d_wr_en, alu_op,
           instr_rd_en, instr_flush, pc_incr_en, pc_j_en, stack_push, stack_pop, pc_ret_en
  );
endinterface

// File: rtl/instr_sequencer_q_phase_counter.sv
// Free-running Q-phase counter with synchronous reset, a hold input used while halted,
// and a flag marking the last phase of the instruction.
module q_phase_counter #(
  parameter int Q_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hold,
  output logic [Q_W-1:0] q,
  output logic           qlast
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (!hold)
      q <= q + Q_W'(1);
  end

  assign qlast = (q == {Q_W{1'b1}});

endmodule

// File: rtl/instr_sequencer.sv
// Q-cycle instruction sequencer for the PIC16F-class core (EXEC / FLUSH / HALT).
// Define SEQ_CALL_RETURN_EN to enable CALL, RETURN and RETLW; otherwise they run as NOP.
module instr_sequencer
  import pic_isa_pkg::*;
#(
  parameter int INSTR_W  = 14,
  parameter int ALU_OP_W = 4,
  parameter int Q_W      = 2
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);

`ifdef SEQ_CALL_RETURN_EN
  localparam bit CALL_RET_EN = 1'b1;
`else
  localparam bit CALL_RET_EN = 1'b0;
`endif

  localparam logic [Q_W-1:0] Q2 = Q_W'(2);

  seq_state_e         state;
  logic               skip_q;
  logic [Q_W-1:0]     q;
  logic               qlast;
  logic [INSTR_W-1:0] instr;
  decode_t            dec;

  logic       status_wr_c, sel_l_c, d_c, d_wr_c;
  logic [3:0] op_c;
  logic       rd_c, flush_c, incr_c, jump_c, push_c, pop_c, ret_c;

  assign instr = bus.instr_current;
  assign dec   = decode_instr(instr[ISA_W-1:0]);

  q_phase_counter #(.Q_W(Q_W)) u_q_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .hold  (state == HALT),
    .q     (q),
    .qlast (qlast)
  );

  // halt_req is only honoured at an instruction boundary, and never ahead of a pending flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EXEC;
      skip_q <= 1'b0;
    end else begin
      if (state == EXEC && q == Q2 && dec.cls == C_SKIP)
        skip_q <= bus.skip_cond;
      else if (qlast)
        skip_q <= 1'b0;
      case (state)
        EXEC:    if (qlast) state <= flush_c ? FLUSH : (bus.halt_req ? HALT : EXEC);
        FLUSH:   if (qlast) state <= bus.halt_req ? HALT : EXEC;
        HALT:    if (!bus.halt_req) state <= EXEC;
        default: state <= EXEC;
      endcase
    end
  end

  always_comb begin
    status_wr_c = 1'b0;
    sel_l_c     = 1'b0;
    d_c         = instr[7];
    d_wr_c      = 1'b0;
    op_c        = ALU_NOP;
    rd_c        = 1'b0;
    flush_c     = 1'b0;
    incr_c      = 1'b0;
    jump_c      = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    ret_c       = 1'b0;

    if (state == EXEC && q == Q2) begin
      case (dec.cls)
        C_ALU, C_SKIP: begin
          op_c        = dec.op;
          d_wr_c      = 1'b1;
          status_wr_c = dec.status_wr;
          sel_l_c     = dec.literal;
          if (dec.literal) d_c = 1'b0;
        end
        C_RETLW: if (CALL_RET_EN) begin
          op_c    = ALU_PASS_L;
          d_wr_c  = 1'b1;
          sel_l_c = 1'b1;
          d_c     = 1'b0;
        end
        default: ;
      endcase
    end

    // Redirecting instructions replace the sequential fetch with a jump/return plus flush.
    if (state == EXEC && qlast) begin
      if (dec.cls == C_GOTO) begin
        jump_c  = 1'b1;
        flush_c = 1'b1;
      end else if (CALL_RET_EN && dec.cls == C_CALL) begin
        push_c  = 1'b1;
        jump_c  = 1'b1;
        flush_c = 1'b1;
      end else if (CALL_RET_EN && (dec.cls == C_RET || dec.cls == C_RETLW)) begin
        pop_c   = 1'b1;
        ret_c   = 1'b1;
        flush_c = 1'b1;
      end else begin
        rd_c    = 1'b1;
        incr_c  = 1'b1;
        flush_c = (dec.cls == C_SKIP) && skip_q;
      end
    end

    if (state == FLUSH && qlast) begin
      rd_c   = 1'b1;
      incr_c = 1'b1;
    end

    if (rst) begin
      {status_wr_c, sel_l_c, d_c, d_wr_c} = '0;
      op_c = ALU_NOP;
      {rd_c, flush_c, incr_c, jump_c, push_c, pop_c, ret_c} = '0;
    end
  end

  assign bus.halted           = !rst && (state == HALT);
  assign bus.q_phase          = rst ? '0 : q;
  assign bus.alu_status_wr_en = status_wr_c;
  assign bus.alu_sel_l        = sel_l_c;
  assign bus.alu_d            = d_c;
  assign bus.alu_d_wr_en      = d_wr_c;
  assign bus.alu_op           = ALU_OP_W'(op_c);
  assign bus.instr_rd_en      = rd_c;
  assign bus.instr_flush      = flush_c;
  assign bus.pc_incr_en       = incr_c;
  assign bus.pc_j_en          = jump_c;
  assign bus.stack_push       = push_c;
  assign bus.stack_pop        = pop_c;
  assign bus.pc_ret_en        = ret_c;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed by random
// instruction streams, all compared per clock against an instruction-level model.
module tb_instr_sequencer;
  import pic_isa_pkg::*;

`ifdef SEQ_CALL_RETURN_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  localparam int K_NOP = 0, K_ALU = 1, K_SKIP = 2, K_GOTO = 3, K_CALL = 4, K_RET = 5, K_RETLW = 6;
  localparam int I_NOP = 0, I_ADDWF = 1, I_MOVWF = 2, I_GOTO = 3, I_DECFSZ = 4;
  localparam int N_INSTR = 26;

  typedef struct {
    logic [13:0] base;
    logic [13:0] mask;
    int          kind;
    logic [3:0]  op;
    bit          st;
    bit          lit;
  } ientry_t;

  // Generator table: each entry knows the behaviour its mnemonic must produce.
  ientry_t tbl [N_INSTR] = '{
    '{14'h0000, 14'h0000, K_NOP,   ALU_NOP,    1'b0, 1'b0},
    '{14'h0700, 14'h00FF, K_ALU,   ALU_ADD,    1'b1, 1'b0},
    '{14'h0080, 14'h007F, K_ALU,   ALU_PASS_W, 1'b0, 1'b0},
    '{14'h2800, 14'h07FF, K_GOTO,  ALU_NOP,    1'b0, 1'b0},
    '{14'h0B00, 14'h00FF, K_SKIP,  ALU_DEC,    1'b1, 1'b0},
    '{14'h0200, 14'h00FF, K_ALU,   ALU_SUB,    1'b1, 1'b0},
    '{14'h0500, 14'h00FF, K_ALU,   ALU_AND,    1'b1, 1'b0},
    '{14'h0400, 14'h00FF, K_ALU,   ALU_IOR,    1'b1, 1'b0},
    '{14'h0600, 14'h00FF, K_ALU,   ALU_XOR,    1'b1, 1'b0},
    '{14'h0180, 14'h007F, K_ALU,   ALU_CLR,    1'b1, 1'b0},
    '{14'h0100, 14'h007F, K_ALU,   ALU_CLR,    1'b1, 1'b0},
    '{14'h0A00, 14'h00FF, K_ALU,   ALU_INC,    1'b1, 1'b0},
    '{14'h0300, 14'h00FF, K_ALU,   ALU_DEC,    1'b1, 1'b0},
    '{14'h0900, 14'h00FF, K_ALU,   ALU_COM,    1'b1, 1'b0},
    '{14'h0800, 14'h00FF, K_ALU,   ALU_PASS_F, 1'b1, 1'b0},
    '{14'h3000, 14'h03FF, K_ALU,   ALU_PASS_L, 1'b0, 1'b1},
    '{14'h3E00, 14'h01FF, K_ALU,   ALU_ADD,    1'b1, 1'b1},
    '{14'h3900, 14'h00FF, K_ALU,   ALU_AND,    1'b1, 1'b1},
    '{14'h0F00, 14'h00FF, K_SKIP,  ALU_INC,    1'b1, 1'b0},
    '{14'h1800, 14'h03FF, K_SKIP,  ALU_BTST,   1'b1, 1'b0},
    '{14'h1C00, 14'h03FF, K_SKIP,  ALU_BTST,   1'b1, 1'b0},
    '{14'h2000, 14'h07FF, K_CALL,  ALU_NOP,    1'b0, 1'b0},
    '{14'h0008, 14'h0000, K_RET,   ALU_NOP,    1'b0, 1'b0},
    '{14'h3400, 14'h03FF, K_RETLW, ALU_PASS_L, 1'b0, 1'b1},
    '{14'h1400, 14'h03FF, K_NOP,   ALU_NOP,    1'b0, 1'b0},
    '{14'h3800, 14'h00FF, K_NOP,   ALU_NOP,    1'b0, 1'b0}
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, fails = 0;
  int cur = 0;
  logic [13:0] cur_word = '0;
  int m_ph = 0;
  bit m_flush = 1'b0, m_halt = 1'b0, m_skip = 1'b0;
  int fetches = 0, flushes = 0, jumps = 0, win = 0, last_fetch = -1;

  function automatic logic [17:0] model_out(input bit rs);
    logic hd, st, sl, ad, dw, rd, fl, inc, pj, pu, po, pr;
    logic [1:0] qq;
    logic [3:0] op;
    int k;
    {hd, st, sl, ad, dw, rd, fl, inc, pj, pu, po, pr} = '0;
    qq = '0;
    op = ALU_NOP;
    k  = tbl[cur].kind;
    if (!rs) begin
      ad = cur_word[7];
      if (m_halt) hd = 1'b1;
      else begin
        qq = 2'(m_ph);
        if (m_flush) begin
          if (m_ph == 3) {rd, inc} = 2'b11;
        end else if (m_ph == 2) begin
          if (k == K_ALU || k == K_SKIP) begin
            op = tbl[cur].op; dw = 1'b1; st = tbl[cur].st; sl = tbl[cur].lit;
            if (tbl[cur].lit) ad = 1'b0;
          end else if (k == K_RETLW && CR) begin
            op = ALU_PASS_L; dw = 1'b1; sl = 1'b1; ad = 1'b0;
          end
        end else if (m_ph == 3) begin
          if (k == K_GOTO) {pj, fl} = 2'b11;
          else if (CR && k == K_CALL) {pu, pj, fl} = 3'b111;
          else if (CR && (k == K_RET || k == K_RETLW)) {po, pr, fl} = 3'b111;
          else begin
            {rd, inc} = 2'b11;
            if (k == K_SKIP) fl = m_skip;
          end
        end
      end
    end
    return {hd, qq, st, sl, ad, dw, op, rd, fl, inc, pj, pu, po, pr};
  endfunction

  function automatic void model_step(input bit sk, input bit hr, input bit rs);
    int k;
    bit redirect;
    k = tbl[cur].kind;
    if (rs) begin
      m_ph = 0; m_flush = 1'b0; m_halt = 1'b0; m_skip = 1'b0;
    end else if (m_halt) begin
      if (!hr) m_halt = 1'b0;
    end else begin
      if (!m_flush && m_ph == 2 && k == K_SKIP) m_skip = sk;
      if (m_ph == 3) begin
        redirect = !m_flush && (k == K_GOTO || (CR && (k == K_CALL || k == K_RET || k == K_RETLW))
                                || (k == K_SKIP && m_skip));
        m_skip = 1'b0;
        m_ph   = 0;
        if (redirect) m_flush = 1'b1;
        else begin
          m_flush = 1'b0;
          m_halt  = hr;
        end
      end else begin
        m_ph++;
      end
    end
  endfunction

  task automatic load(input int idx, input logic [13:0] force_bits);
    logic [13:0] r;
    r = 14'($urandom);
    cur = idx;
    cur_word = tbl[idx].base | (r & tbl[idx].mask) | force_bits;
  endtask

  task automatic clear_window();
    fetches = 0; flushes = 0; jumps = 0; win = 0; last_fetch = -1;
  endtask

  task automatic cycle(input string tag, input bit sk, input bit hr, input bit rs);
    logic [17:0] obs_v, exp_v;
    bus.instr_current = cur_word;
    bus.skip_cond     = sk;
    bus.halt_req      = hr;
    rst               = rs;
    #1;
    exp_v = model_out(rs);
    obs_v = {bus.halted, bus.q_phase, bus.alu_status_wr_en, bus.alu_sel_l, bus.alu_d,
             bus.alu_d_wr_en, bus.alu_op, bus.instr_rd_en, bus.instr_flush, bus.pc_incr_en,
             bus.pc_j_en, bus.stack_push, bus.stack_pop, bus.pc_ret_en};
    checks++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("[TB] FAIL %s win=%0d instr=%h observed=%h expected=%h", tag, win, cur_word, obs_v, exp_v);
    end
    if (bus.instr_rd_en === 1'b1) begin fetches++; last_fetch = win; end
    if (bus.instr_flush === 1'b1) flushes++;
    if (bus.pc_j_en === 1'b1) jumps++;
    win++;
    model_step(sk, hr, rs);
    @(negedge clk);
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    checks++;
    assert (observed == expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int n;
    bit hr_r;
    rst = 1'b1;
    bus.instr_current = '0;
    bus.skip_cond = 1'b0;
    bus.halt_req = 1'b0;

    load(I_GOTO, 14'h0);
    repeat (3) cycle("reset", 1'b1, 1'b1, 1'b1);

    load(I_NOP, 14'h0);
    clear_window();
    repeat (8) cycle("nop_stream", 1'b0, 1'b0, 1'b0);
    check_int("nop_fetch_count", fetches, 2);
    check_int("nop_fetch_phase", last_fetch, 7);

    load(I_ADDWF, 14'h0080);
    repeat (4) cycle("addwf_d1", 1'b0, 1'b0, 1'b0);
    load(I_MOVWF, 14'h0);
    repeat (4) cycle("movwf", 1'b0, 1'b0, 1'b0);

    load(I_GOTO, 14'h0);
    clear_window();
    repeat (8) cycle("goto", 1'b0, 1'b0, 1'b0);
    check_int("goto_fetches", fetches, 1);
    check_int("goto_flushes", flushes, 1);
    check_int("goto_fetch_at", last_fetch, 7);

    load(I_DECFSZ, 14'h0);
    clear_window();
    repeat (8) cycle("decfsz_taken", m_ph == 2 && !m_flush, 1'b0, 1'b0);
    check_int("decfsz_taken_flush", flushes, 1);
    check_int("decfsz_taken_len", last_fetch, 7);

    load(I_DECFSZ, 14'h0);
    clear_window();
    repeat (4) cycle("decfsz_q1q3", m_ph == 1 || m_ph == 3, 1'b0, 1'b0);
    check_int("decfsz_q1q3_flush", flushes, 0);
    check_int("decfsz_q1q3_len", last_fetch, 3);

    load(I_NOP, 14'h0);
    cycle("halt_pre", 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.halted !== 1'b1 && n < 12) begin
      cycle("halt_req", 1'b0, 1'b1, 1'b0);
      n++;
    end
    check_int("halt_entry_clocks", n, 3);
    repeat (3) cycle("halted", 1'b0, 1'b1, 1'b0);
    cycle("halt_release", 1'b0, 1'b0, 1'b0);
    clear_window();
    repeat (4) cycle("halt_resume", 1'b0, 1'b0, 1'b0);
    check_int("resume_fetch_at", last_fetch, 3);

    load(I_DECFSZ, 14'h0);
    repeat (4) cycle("skip_halt", m_ph == 2, m_ph == 3, 1'b0);
    repeat (4) cycle("skip_halt_flush", 1'b0, 1'b1, 1'b0);
    check_int("halt_after_flush", int'(bus.halted), 1);
    cycle("skip_halt_release", 1'b0, 1'b0, 1'b0);

    load(I_GOTO, 14'h0);
    cycle("goto_q0", 1'b0, 1'b0, 1'b0);
    cycle("goto_q1", 1'b0, 1'b0, 1'b0);
    clear_window();
    cycle("goto_rst_q2", 1'b0, 1'b0, 1'b1);
    load(I_NOP, 14'h0);
    repeat (4) cycle("after_rst", 1'b0, 1'b0, 1'b0);
    check_int("rst_no_jump", jumps, 0);
    check_int("rst_no_flush", flushes, 0);

    hr_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_halt && !m_flush && m_ph == 0) load($urandom_range(0, N_INSTR - 1), 14'h0);
      if (hr_r) hr_r = ($urandom_range(0, 3) != 0);
      else      hr_r = ($urandom_range(0, 59) == 0);
      cycle("random", 1'($urandom_range(0, 1)), hr_r, $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
